// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, FSM state encodings and the
// oversampling divider calculation used by the echo core.
package uart_pkg;

  // 8N1 framing
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // The receiver runs on a half-bit tick. The stop bit is judged this many
  // ticks after the tick that first saw the start bit low.
  localparam int RX_STOP_TICK = 2 * (DATA_BITS + STOP_BITS);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_STOP = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Clocks per half bit period (truncating). The result must be at least 2.
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / (2 * baud);
  endfunction

endpackage

// File: rtl/uart_echo_core_if.sv
// Byte handshake bundle: a one-cycle strobe with its data byte, plus a busy
// indication flowing back from the consumer.
interface uart_echo_core_if;
  logic       vld;
  logic [7:0] data;
  logic       busy;

  modport master (output vld, data, input busy);
  modport slave  (input vld, data, output busy);
endinterface

// File: rtl/clock_divider.sv
// Free-running divider producing the half-bit enable pulse (twice the bit
// rate). The pulse is high in the cycle the counter sits at its last value.
module clock_divider
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK  = 27000000,
  parameter int OUTPUT_CLOCK = 9600      // bit rate; clk_en runs at twice this
) (
  input  logic clk,
  input  logic rst,
  output logic clk_en
);

  localparam int DIV = uart_div(INPUT_CLOCK, OUTPUT_CLOCK);
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  // count 0..DIV-1 and wrap
  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign clk_en = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver sampling on the half-bit tick. The start bit is seen on some
// half-bit tick; every second tick after that lands inside the next bit.
// A bad stop bit drops the byte and blocks new starts until the line has
// been seen idle, so a stuck-low line is not read as a stream of zeros.
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick2x,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
);

  localparam logic [4:0] LAST_DATA_TICK = 5'(2 * DATA_BITS);
  localparam logic [4:0] STOP_TICK      = 5'(RX_STOP_TICK);

  logic [1:0] r_sync;
  logic       w_rx;
  rx_state_e  r_state;
  logic [4:0] r_tcnt;
  logic [4:0] w_tcnt_nxt;
  logic [7:0] r_shift;
  logic       r_wait_high;

  // two-flop synchronizer; resets to the idle level
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], i_rx};
  end

  assign w_rx       = r_sync[1];
  assign w_tcnt_nxt = r_tcnt + 5'd1;

  // frame FSM: r_tcnt counts half-bit ticks since the start was seen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_tcnt      <= '0;
      r_shift     <= '0;
      r_wait_high <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_tick2x) begin
        case (r_state)
          RX_IDLE: begin
            if (r_wait_high) begin
              if (w_rx) r_wait_high <= 1'b0;
            end else if (!w_rx) begin
              r_state <= RX_DATA;
              r_tcnt  <= '0;
            end
          end
          RX_DATA: begin
            r_tcnt <= w_tcnt_nxt;
            if (!w_tcnt_nxt[0]) r_shift <= {w_rx, r_shift[7:1]};
            if (w_tcnt_nxt == LAST_DATA_TICK) r_state <= RX_STOP;
          end
          RX_STOP: begin
            r_tcnt <= w_tcnt_nxt;
            if (w_tcnt_nxt == STOP_TICK) begin
              r_state <= RX_IDLE;
              if (w_rx) begin
                o_data  <= r_shift;
                o_valid <= 1'b1;
              end else begin
                r_wait_high <= 1'b1;
              end
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter. The line only moves on the bit tick. A launch that
// coincides with a bit tick starts the start bit at once, so a frame issued
// on a tick occupies exactly ten bit periods of busy.
module uart_tx
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_tick1x,
  uart_echo_core_if.slave tx_if,
  output logic o_tx
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS);

  tx_state_e  r_state;
  logic [7:0] r_byte;
  logic [3:0] r_bit;
  logic       r_busy;

  assign tx_if.busy = r_busy;

  // frame FSM; launches outside IDLE are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_byte  <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      o_tx    <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (tx_if.vld) begin
            r_byte <= tx_if.data;
            r_bit  <= '0;
            r_busy <= 1'b1;
            if (i_tick1x) begin
              o_tx    <= 1'b0;
              r_state <= TX_DATA;
            end else begin
              r_state <= TX_START;
            end
          end
        end
        TX_START: begin
          if (i_tick1x) begin
            o_tx    <= 1'b0;
            r_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (i_tick1x) begin
            if (r_bit == LAST_BIT) begin
              o_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              o_tx   <= r_byte[0];
              r_byte <= {1'b0, r_byte[7:1]};
              r_bit  <= r_bit + 4'd1;
            end
          end
        end
        TX_STOP: begin
          if (i_tick1x) begin
            r_busy  <= 1'b0;
            r_state <= TX_IDLE;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_core.sv
// UART echo: every correctly framed byte is sent back out. Only the newest
// unsent byte is held; a byte arriving before the previous one launched
// replaces it.
module uart_echo_core
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK = 27000000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_busy
);

  logic w_tick2x;
  logic w_tick1x;
  logic r_phase;
  logic r_pend;
  logic w_launch;

  uart_echo_core_if w_tx_if ();

  clock_divider #(
    .INPUT_CLOCK (INPUT_CLOCK),
    .OUTPUT_CLOCK(BAUD_RATE)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .clk_en(w_tick2x)
  );

  // phase splits the half-bit tick into one pulse per bit period
  always_ff @(posedge clk) begin
    if (rst)           r_phase <= 1'b0;
    else if (w_tick2x) r_phase <= ~r_phase;
  end

  assign w_tick1x = w_tick2x & r_phase;

  uart_rx u_rx (
    .clk     (clk),
    .rst     (rst),
    .i_tick2x(w_tick2x),
    .i_rx    (rx),
    .o_data  (rx_data),
    .o_valid (rx_valid)
  );

  // launch on a bit tick whenever a byte waits and the transmitter is free
  assign w_launch = w_tick1x & r_pend & ~w_tx_if.busy;

  // a fresh byte wins over a launch in the same cycle
  always_ff @(posedge clk) begin
    if (rst)           r_pend <= 1'b0;
    else if (rx_valid) r_pend <= 1'b1;
    else if (w_launch) r_pend <= 1'b0;
  end

  assign w_tx_if.vld  = w_launch;
  assign w_tx_if.data = rx_data;
  assign tx_busy      = w_tx_if.busy;

  uart_tx u_tx (
    .clk     (clk),
    .rst     (rst),
    .i_tick1x(w_tick1x),
    .tx_if   (w_tx_if.slave),
    .o_tx    (tx)
  );

endmodule

// File: tb/tb_uart_echo_core.sv
// Bench for uart_echo_core at 160 Hz / 10 baud (half-bit = 8 clk, bit = 16 clk).
// Reference: queues of bytes expected on rx_valid and on the tx line; the tx
// line is decoded independently by sampling mid-bit.
module tb_uart_echo_core;

  localparam int CLK_HZ = 160;
  localparam int BAUD   = 10;
  localparam int BIT    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  // the bundle doubles as a monitor: vld/data carry rx_valid/rx_data
  uart_echo_core_if mon_if ();

  uart_echo_core #(
    .INPUT_CLOCK(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .tx      (tx),
    .rx_data (mon_if.data),
    .rx_valid(mon_if.vld),
    .tx_busy (mon_if.busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] last_good = 8'h00;
  bit         mon_on   = 1'b0;
  bit         txmon_on = 1'b0;
  logic       rxv_prev = 1'b0;
  int         bcnt     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // drive one frame; stop_ok=0 drives a low stop bit
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      exp_rx.push_back(b);
      exp_tx.push_back(b);
    end
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    if (stop_ok) last_good = b;
    else         chk("ferr_data", mon_if.data, last_good);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000; i++) begin
      if (exp_tx.size() == 0 && !mon_if.busy) break;
      @(negedge clk);
    end
    chk("drain_q", exp_tx.size(), 0);
    chk("drain_busy", mon_if.busy, 0);
  endtask

  // rx_valid pulses against the expected-byte queue; idle line level
  always @(negedge clk) begin
    if (mon_on) begin
      if (mon_if.vld) begin
        chk("rxv_width", rxv_prev, 0);
        chk("rx_expected", exp_rx.size() > 0, 1);
        if (exp_rx.size() > 0) chk("rx_data", mon_if.data, exp_rx.pop_front());
      end
      if (!mon_if.busy) chk("tx_idle_hi", tx, 1);
    end
    rxv_prev <= mon_if.vld;
  end

  // busy must last exactly ten bit periods per echoed frame
  always @(negedge clk) begin
    if (mon_on) begin
      if (mon_if.busy) bcnt <= bcnt + 1;
      else begin
        if (bcnt != 0 && txmon_on) chk("busy_len", bcnt, 10 * BIT);
        bcnt <= 0;
      end
    end
  end

  // decode the tx line mid-bit
  initial begin : txdec
    logic [9:0] f;
    forever begin
      @(negedge clk);
      if (txmon_on && tx === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        f[0] = tx;
        for (int j = 1; j < 10; j++) begin
          repeat (BIT) @(negedge clk);
          f[j] = tx;
        end
        chk("tx_start", f[0], 0);
        chk("tx_stop", f[9], 1);
        chk("tx_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) chk("tx_byte", f[8:1], exp_tx.pop_front());
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : main
    int act;
    logic [7:0] b;
    bit ok;

    // reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", mon_if.busy, 0);
    chk("rst_vld", mon_if.vld, 0);
    chk("rst_data", mon_if.data, 8'h00);
    mon_on   = 1'b1;
    txmon_on = 1'b1;

    // tick timing after release: cycle 1 is the first cycle out of reset
    rst = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      chk("tick2x", dut.w_tick2x, (c % 8) == 0);
      chk("tick1x", dut.w_tick1x, (c % 16) == 0);
      @(negedge clk);
    end

    // single good frame and its echo
    send_frame(8'hA5, 1'b1);
    chk("rx_hold_a5", mon_if.data, 8'hA5);
    wait_drain();

    // framing error: no byte, no echo
    send_frame(8'h3C, 1'b0);
    idle(40);
    chk("ferr_busy", mon_if.busy, 0);
    chk("ferr_hold", mon_if.data, 8'hA5);
    idle(40);

    // back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain();
    chk("b2b_last", mon_if.data, 8'hFF);

    // random frames, some with a bad stop bit
    for (int n = 0; n < 14; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(3) != 0);
      send_frame(b, ok);
      idle($urandom_range(24, 60));
    end
    wait_drain();
    chk("rand_last", mon_if.data, last_good);

    // reset during echo data bit 3 of 8'h5A
    txmon_on = 1'b0;
    send_frame(8'h5A, 1'b1);
    for (int i = 0; i < 100 && !mon_if.busy; i++) @(negedge clk);
    chk("echo_start", mon_if.busy, 1);
    repeat (54) @(negedge clk);
    chk("echo_bit2", tx, 0);
    repeat (16) @(negedge clk);
    chk("echo_bit3", tx, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_busy", mon_if.busy, 0);
    chk("abort_vld", mon_if.vld, 0);
    chk("abort_data", mon_if.data, 8'h00);
    rst = 1'b0;
    exp_tx.delete();
    last_good = 8'h00;
    act = 0;
    for (int i = 0; i < 300; i++) begin
      if (mon_if.busy || !tx) act++;
      @(negedge clk);
    end
    chk("post_rst_quiet", act, 0);

    // recovery after reset
    txmon_on = 1'b1;
    send_frame(8'hC3, 1'b1);
    wait_drain();
    chk("rxq_empty", exp_rx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_echo_core.md
UART_ECHO_CORE -- requirements
Module: uart_echo_core

Interface
REQ-001 SHALL have parameter INPUT_CLOCK, default 27000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate in bit/s; 8N1 framing, LSB first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial input, idle high.
REQ-006 SHALL have port tx, output, 1 bit: serial output, idle high.
REQ-007 SHALL have port rx_data, output, 8 bits: last correctly framed received byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-009 SHALL have port tx_busy, output, 1 bit: transmitter is sending a frame.

Function
REQ-010 Divider: DIV = INPUT_CLOCK/(2*BAUD_RATE), integer truncation (1406 at defaults); counter runs 0..DIV-1 and wraps; tick2x is a one-cycle pulse in the cycle the counter equals DIV-1.
REQ-011 Phase bit toggles on every tick2x; tick1x = tick2x AND phase, giving one pulse per bit period.
REQ-012 rx passes through a 2-flop synchronizer before any use.
REQ-013 RX FSM states: IDLE, DATA, STOP.
- IDLE: a tick2x that samples rx low marks t0 and moves to DATA.
- DATA: bit i (0..7) is sampled at tick2x t0+2(i+1) and shifted in LSB first.
- STOP: the stop bit is sampled at tick2x t0+18.
REQ-014 Stop bit = 1: rx_data loads the byte and rx_valid pulses for exactly one clk; FSM returns to IDLE.
REQ-015 Stop bit = 0 (framing error): no rx_valid, rx_data unchanged, no echo; FSM waits in IDLE until a tick2x samples rx high before it accepts a new start bit.
REQ-016 TX FSM states: IDLE, START, DATA, STOP.
- A launch accepted in IDLE latches the byte and sets tx_busy on the next clk.
- tx changes only on tick1x: start bit 0 on the first tick1x, then data bits LSB first, then stop bit 1.
- tx_busy clears at the tick1x that ends the stop bit; each frame lasts 10 bit periods.
REQ-017 Echo: rx_valid sets a pending flag.
- When tick1x AND pending AND NOT tx_busy, the core issues a one-cycle launch carrying the current rx_data and clears pending.
- If rx_valid and a launch occur in the same cycle, pending stays set.
REQ-018 A byte received while pending is still set overwrites rx_data; only the newest byte is echoed (no queue).
REQ-019 A launch is ignored while tx_busy = 1.

Reset
REQ-020 While rst = 1 at a clk edge, the following SHALL take these values on the next cycle:
- divider counter 0; phase 0; synchronizer flops 1;
- both FSMs IDLE; pending 0;
- tx 1; tx_busy 0; rx_valid 0; rx_data 8'h00.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately with no partial rx_valid.
REQ-022 After reset release, the first tick2x SHALL occur exactly DIV cycles later.

Structure
REQ-023 A shared package uart_pkg SHALL hold the RX/TX state enums, the frame constants (8 data bits, 1 stop bit) and a function computing DIV.
REQ-024 clock_divider SHALL be the natural sub-module, with ports clk, rst, clk_en and parameters INPUT_CLOCK, OUTPUT_CLOCK.
REQ-025 uart_rx and uart_tx SHALL be separate sub-modules; the phase bit and echo logic sit in the top level.

Verification (INPUT_CLOCK=160, BAUD_RATE=10 → DIV=8, bit period 16 clk)
REQ-026 Release reset -> tick2x pulses at cycles 8, 16, 24, ...; tick1x at cycles 16, 32, ...
REQ-027 Drive 8'hA5 at 16 clk/bit -> exactly one rx_valid pulse with rx_data = 8'hA5.
REQ-028 Same frame, echo path -> tx emits 0,1,0,1,0,0,1,0,1,1 at 16 clk per bit; tx_busy is high for 160 clk, then tx stays 1.
REQ-029 Frame 8'h3C with stop bit 0 -> no rx_valid, rx_data unchanged, tx stays 1.
REQ-030 Back-to-back frames 8'h00 then 8'hFF -> two rx_valid pulses and both bytes echoed in order.
REQ-031 Assert rst during echo data bit 3 -> next cycle tx = 1, tx_busy = 0, no further output.
